// File: rtl/mc_seq_if.sv
// mc_seq_if: sequencer-to-datapath/memory bundle; master is the sequencer side
interface mc_seq_if #(
    parameter int CNT_W = 32
) ();
    logic             run;
    logic [31:0]      mem_rdata;
    logic             mem_ready;
    logic [10:0]      ctrl_in;
    logic [31:0]      ir_out;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             pc_we;
    logic             rf_we;
    logic             rf_dst;
    logic             wb_sel;
    logic             alu_src;
    logic [5:0]       alu_funct;
    logic [2:0]       state;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, mem_rdata, mem_ready, ctrl_in,
        output ir_out, mem_req, mem_we, addr_sel, pc_we, rf_we, rf_dst, wb_sel,
               alu_src, alu_funct, state, fault, retired
    );

    modport slave (
        output run, mem_rdata, mem_ready, ctrl_in,
        input  ir_out, mem_req, mem_we, addr_sel, pc_we, rf_we, rf_dst, wb_sel,
               alu_src, alu_funct, state, fault, retired
    );
endinterface

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with retire counter and fault detection
module mc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic      clk,
    input logic      rst_n,
    mc_seq_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd7
    } state_t;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

    state_t           st;
    logic [31:0]      ir;
    logic [10:0]      ctrl_q;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] retired;
    logic             fault;
    logic             alu_on;

    // state sequencing, instruction/control capture, wait timer and retire count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            ir       <= '0;
            ctrl_q   <= '0;
            wait_cnt <= '0;
            retired  <= '0;
            fault    <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    wait_cnt <= '0;
                    st       <= bus.run ? FETCH : IDLE;
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir       <= bus.mem_rdata;
                        wait_cnt <= '0;
                        st       <= DECODE;
                    end else if (wait_cnt == LAST) begin
                        st    <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    ctrl_q <= bus.ctrl_in;
                    if (ir == '0) begin
                        retired  <= retired + CNT_W'(1);
                        wait_cnt <= '0;
                        st       <= bus.run ? FETCH : IDLE;
                    end else if (bus.ctrl_in == '0) begin
                        st    <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        st <= EXEC;
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    st       <= (ctrl_q[10] | ctrl_q[9]) ? MEM : WB;
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        if (ctrl_q[9]) begin
                            retired <= retired + CNT_W'(1);
                            st      <= bus.run ? FETCH : IDLE;
                        end else begin
                            st <= WB;
                        end
                    end else if (wait_cnt == LAST) begin
                        st    <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB: begin
                    retired  <= retired + CNT_W'(1);
                    wait_cnt <= '0;
                    st       <= bus.run ? FETCH : IDLE;
                end
                default: st <= FAULT;
            endcase
        end
    end

    // per-state strobes decoded from the current state and the latched control word
    always_comb begin
        alu_on        = (st == EXEC) || (st == MEM) || (st == WB);
        bus.mem_req   = (st == FETCH) || (st == MEM);
        bus.addr_sel  = (st == MEM);
        bus.mem_we    = (st == MEM) && ctrl_q[9];
        bus.pc_we     = (st == FETCH) && bus.mem_ready;
        bus.rf_we     = (st == WB) && ctrl_q[6];
        bus.rf_dst    = (st == WB) && ctrl_q[7];
        bus.wb_sel    = (st == WB) && ctrl_q[10];
        bus.alu_src   = alu_on && ctrl_q[8];
        bus.alu_funct = alu_on ? ctrl_q[5:0] : 6'd0;
    end

    assign bus.ir_out  = ir;
    assign bus.state   = st;
    assign bus.fault   = fault;
    assign bus.retired = retired;
endmodule
